// File: rtl/adc_sched_pkg.sv
// rtl/adc_sched_pkg.sv - shared types, widths and helpers for the ADC scan scheduler
// Contents: sched_state_t FSM encoding, ADC_RES_W / CH_W word widths,
//           sel_width() select-width helper, raw_word() / offset_word() result formatters.
package adc_sched_pkg;

    localparam int ADC_RES_W = 12;
    localparam int CH_W      = 16;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        START,
        WAIT,
        NEXT,
        DONE
    } sched_state_t;

    function automatic int sel_width(input int n_ch);
        return (n_ch > 1) ? $clog2(n_ch) : 1;
    endfunction

    // Unsigned conversion result, zero-extended to the published word width.
    function automatic logic [CH_W-1:0] raw_word(input logic [ADC_RES_W-1:0] raw);
        return {{(CH_W-ADC_RES_W){1'b0}}, raw};
    endfunction

    // Offset-corrected result: 13-bit two's complement difference, sign-extended.
    function automatic logic [CH_W-1:0] offset_word(input logic [ADC_RES_W-1:0] raw,
                                                    input logic [ADC_RES_W-1:0] off);
        logic [ADC_RES_W:0] diff;
        diff = {1'b0, raw} - {1'b0, off};
        return {{(CH_W-ADC_RES_W-1){diff[ADC_RES_W]}}, diff};
    endfunction

endpackage

// File: rtl/adc_done_edge.sv
// rtl/adc_done_edge.sv - ADC done-level register and rising-edge pulse
// Ports: clk, rst_n (async active-low) | done: ADC done level | done_rise: one-cycle rise pulse
module adc_done_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic done,
    output logic done_rise
);

    logic done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q <= 1'b0;
        end else begin
            done_q <= done;
        end
    end

    // A done level that stays high produces exactly one pulse.
    assign done_rise = done & ~done_q;

endmodule

// File: rtl/adc_scan_scheduler.sv
// rtl/adc_scan_scheduler.sv - PWM-triggered scan of N_CH mux channels through one shared SPI ADC
// Ports: clk, rst_n (async active-low)
//        trig          scan request pulse
//        adc_data      ADC result, bits [11:0] used
//        adc_done      ADC done level
//        adc_start     one-cycle conversion start
//        mux_sel       analog mux select
//        ch_data       packed frame, channel k at [16k+15:16k]
//        frame_valid   one-cycle pulse when ch_data updates
//        busy          scan in progress
//        overrun       sticky, trig seen while busy
//        timeout_err   sticky, ADC done never rose
// Build option: ADC_OFFSET_CAL_EN - first frame after reset becomes per-channel offsets,
//               later frames publish signed (raw - offset).
module adc_scan_scheduler
    import adc_sched_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int SETTLE_CYC  = 16,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 trig,
    input  logic [15:0]          adc_data,
    input  logic                 adc_done,
    output logic                 adc_start,
    output logic [2:0]           mux_sel,
    output logic [CH_W*N_CH-1:0] ch_data,
    output logic                 frame_valid,
    output logic                 busy,
    output logic                 overrun,
    output logic                 timeout_err
);

    localparam int SEL_W   = sel_width(N_CH);
    localparam int CNT_MAX = (TIMEOUT_CYC > SETTLE_CYC) ? TIMEOUT_CYC : SETTLE_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [SEL_W-1:0] CH_LAST     = SEL_W'(N_CH - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    // The counter is cleared in START and first reads 0 in the first WAIT cycle, so
    // matching TIMEOUT_CYC-2 makes the registered error appear TIMEOUT_CYC cycles after START.
    localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(TIMEOUT_CYC - 2);

    sched_state_t           state;
    logic [SEL_W-1:0]       ch;
    logic [CNT_W-1:0]       cnt;
    logic [ADC_RES_W-1:0]   shadow [N_CH];
    logic                   done_rise;
    logic [3:0]             unused_adc_hi;

`ifdef ADC_OFFSET_CAL_EN
    logic [ADC_RES_W-1:0]   offset [N_CH];
    logic                   cal_done;
`endif

    assign unused_adc_hi = adc_data[15:12];

    adc_done_edge u_done_edge (
        .clk       (clk),
        .rst_n     (rst_n),
        .done      (adc_done),
        .done_rise (done_rise)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ch          <= '0;
            cnt         <= '0;
            adc_start   <= 1'b0;
            mux_sel     <= '0;
            ch_data     <= '0;
            frame_valid <= 1'b0;
            busy        <= 1'b0;
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
            for (int k = 0; k < N_CH; k++) begin
                shadow[k] <= '0;
            end
`ifdef ADC_OFFSET_CAL_EN
            cal_done <= 1'b0;
            for (int k = 0; k < N_CH; k++) begin
                offset[k] <= '0;
            end
`endif
        end else begin
            adc_start   <= 1'b0;
            frame_valid <= 1'b0;

            // Anything other than IDLE, including the DONE cycle, refuses a new scan.
            if (trig && state != IDLE) begin
                overrun <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (trig) begin
                        ch      <= '0;
                        mux_sel <= '0;
                        busy    <= 1'b1;
                        cnt     <= '0;
                        state   <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (cnt == SETTLE_LAST) begin
                        adc_start <= 1'b1;
                        state     <= START;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                START: begin
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (done_rise) begin
                        shadow[ch] <= adc_data[ADC_RES_W-1:0];
                        // Select is updated so the new channel is already driven during NEXT.
                        if (ch != CH_LAST) begin
                            mux_sel <= 3'(ch + 1'b1);
                        end
                        state <= NEXT;
                    end else if (cnt == TO_LAST) begin
                        timeout_err <= 1'b1;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                NEXT: begin
                    if (ch == CH_LAST) begin
                        // Published here so ch_data, frame_valid and busy=0 show in DONE.
`ifdef ADC_OFFSET_CAL_EN
                        if (cal_done) begin
                            for (int k = 0; k < N_CH; k++) begin
                                ch_data[k*CH_W +: CH_W] <= offset_word(shadow[k], offset[k]);
                            end
                            frame_valid <= 1'b1;
                        end else begin
                            for (int k = 0; k < N_CH; k++) begin
                                offset[k] <= shadow[k];
                            end
                            cal_done <= 1'b1;
                        end
`else
                        for (int k = 0; k < N_CH; k++) begin
                            ch_data[k*CH_W +: CH_W] <= raw_word(shadow[k]);
                        end
                        frame_valid <= 1'b1;
`endif
                        busy  <= 1'b0;
                        state <= DONE;
                    end else begin
                        ch    <= ch + 1'b1;
                        cnt   <= '0;
                        state <= SETTLE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_scan_scheduler.sv
// tb/tb_adc_scan_scheduler.sv - self-checking bench for adc_scan_scheduler
module tb_adc_scan_scheduler;

    localparam int N_CH        = 4;
    localparam int SETTLE_CYC  = 16;
    localparam int TIMEOUT_CYC = 1024;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 trig = 1'b0;
    logic [15:0]          adc_data = '0;
    logic                 adc_done = 1'b0;
    logic                 adc_start;
    logic [2:0]           mux_sel;
    logic [16*N_CH-1:0]   ch_data;
    logic                 frame_valid;
    logic                 busy;
    logic                 overrun;
    logic                 timeout_err;

    adc_scan_scheduler #(
        .N_CH        (N_CH),
        .SETTLE_CYC  (SETTLE_CYC),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .trig        (trig),
        .adc_data    (adc_data),
        .adc_done    (adc_done),
        .adc_start   (adc_start),
        .mux_sel     (mux_sel),
        .ch_data     (ch_data),
        .frame_valid (frame_valid),
        .busy        (busy),
        .overrun     (overrun),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    // ADC front-end model configuration
    logic [15:0] resp_data [N_CH];
    int          resp_delay [N_CH];
    bit          hold_mode = 1'b0;
    int          skip_ch = -1;

    // ADC front-end model: answers each start after resp_delay cycles
    bit pend = 1'b0;
    int cd = 0;
    int cur = 0;
    int hi_cnt = 0;
    always @(negedge clk) begin
        if (!adc_done) adc_data = 16'($urandom);
        if (!rst_n) pend = 1'b0;
        if (pend) begin
            cd = cd - 1;
            if (hold_mode && cd == 1) adc_done = 1'b0;
            if (cd == 0) begin
                pend = 1'b0;
                adc_data = resp_data[cur];
                adc_done = 1'b1;
                hi_cnt = 3;
            end
        end else if (adc_done && !hold_mode) begin
            if (hi_cnt > 0) hi_cnt = hi_cnt - 1;
            else adc_done = 1'b0;
        end
        if (adc_start && rst_n && int'(mux_sel) != skip_ch && int'(mux_sel) < N_CH) begin
            pend = 1'b1;
            cd = resp_delay[int'(mux_sel)];
            cur = int'(mux_sel);
        end
    end

    // Event recorder
    int start_q[$], start_sel_q[$], fv_q[$], mchg_q[$], mval_q[$], to_q[$], bfall_q[$];
    logic [2:0] prev_sel = '0;
    logic prev_to = 1'b0, prev_busy = 1'b0;
    always @(negedge clk) begin
        if (adc_start) begin
            start_q.push_back(cyc);
            start_sel_q.push_back(int'(mux_sel));
        end
        if (frame_valid) fv_q.push_back(cyc);
        if (mux_sel != prev_sel) begin
            mchg_q.push_back(cyc);
            mval_q.push_back(int'(mux_sel));
        end
        if (timeout_err && !prev_to) to_q.push_back(cyc);
        if (!busy && prev_busy) bfall_q.push_back(cyc);
        prev_sel = mux_sel;
        prev_to = timeout_err;
        prev_busy = busy;
    end

    // Reference timeline from the latency rules
    int exp_start [N_CH];
    int exp_fv;
    logic [16*N_CH-1:0] last_frame;

    task automatic model_timeline(input int t);
        int s;
        int r;
        s = t + SETTLE_CYC + 1;
        r = 0;
        for (int k = 0; k < N_CH; k++) begin
            exp_start[k] = s;
            r = s + resp_delay[k];
            s = r + SETTLE_CYC + 2;
        end
        exp_fv = r + 2;
    endtask

    function automatic logic [16*N_CH-1:0] exp_frame();
        logic [16*N_CH-1:0] f;
        for (int k = 0; k < N_CH; k++) f[16*k +: 16] = {4'h0, resp_data[k][11:0]};
        return f;
    endfunction

    function automatic int qget(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic clear_events();
        start_q.delete(); start_sel_q.delete(); fv_q.delete(); mchg_q.delete();
        mval_q.delete(); to_q.delete(); bfall_q.delete();
    endtask

    task automatic randomize_resp(input int dmin, input int dmax);
        for (int k = 0; k < N_CH; k++) begin
            resp_data[k] = 16'($urandom);
            resp_delay[k] = $urandom_range(dmax, dmin);
        end
    endtask

    // Pulses trig, optionally a second trig extra_at cycles later, then waits for busy to fall.
    task automatic do_scan(input int extra_at, output int t);
        clear_events();
        trig = 1'b1;
        t = cyc;
        for (int i = 1; i < 6000; i++) begin
            @(negedge clk);
            trig = (extra_at > 0 && i == extra_at);
            if (bfall_q.size() > 0 && i > extra_at) break;
        end
        trig = 1'b0;
        repeat (40) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (adc_start !== 1'b0) begin errors++; $display("FAIL reset_adc_start: got %b expected 0", adc_start); end
        checks++; if (mux_sel !== 3'd0) begin errors++; $display("FAIL reset_mux_sel: got %0d expected 0", mux_sel); end
        checks++; if (ch_data !== '0) begin errors++; $display("FAIL reset_ch_data: got %h expected 0", ch_data); end
        checks++; if ({frame_valid, busy, overrun, timeout_err} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags: got fv/busy/ovr/to=%b expected 0000", {frame_valid, busy, overrun, timeout_err});
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_basic_scan();
        int t;
        resp_data[0] = 16'h0123; resp_data[1] = 16'h0456; resp_data[2] = 16'h0789; resp_data[3] = 16'h0ABC;
        for (int k = 0; k < N_CH; k++) resp_delay[k] = 270;
        do_scan(0, t);
        model_timeline(t);
        checks++; if (start_q.size() != N_CH) begin errors++; $display("FAIL basic_start_count: got %0d expected %0d", start_q.size(), N_CH); end
        for (int k = 0; k < N_CH; k++) begin
            checks++; if (qget(start_q, k) != exp_start[k]) begin errors++; $display("FAIL basic_start_cycle[%0d]: got %0d expected %0d", k, qget(start_q, k), exp_start[k]); end
            checks++; if (qget(start_sel_q, k) != k) begin errors++; $display("FAIL basic_start_sel[%0d]: got %0d expected %0d", k, qget(start_sel_q, k), k); end
        end
        checks++; if (mchg_q.size() != N_CH - 1) begin errors++; $display("FAIL basic_mux_changes: got %0d expected %0d", mchg_q.size(), N_CH - 1); end
        for (int k = 1; k < N_CH; k++) begin
            checks++; if (qget(mchg_q, k - 1) != exp_start[k] - (SETTLE_CYC + 1) || qget(mval_q, k - 1) != k) begin
                errors++; $display("FAIL basic_mux_to_start[%0d]: got change at %0d to %0d expected %0d to %0d", k, qget(mchg_q, k - 1), qget(mval_q, k - 1), exp_start[k] - (SETTLE_CYC + 1), k);
            end
        end
        checks++; if (ch_data !== 64'h0ABC_0789_0456_0123) begin errors++; $display("FAIL basic_ch_data: got %h expected 0abc078904560123", ch_data); end
        checks++; if (fv_q.size() != 1 || qget(fv_q, 0) != exp_fv) begin errors++; $display("FAIL basic_frame_valid: got %0d pulses first at %0d expected 1 at %0d", fv_q.size(), qget(fv_q, 0), exp_fv); end
        checks++; if (qget(bfall_q, 0) != exp_fv) begin errors++; $display("FAIL basic_busy_fall: got %0d expected %0d", qget(bfall_q, 0), exp_fv); end
    endtask

    task automatic test_random_scans();
        int t;
        for (int n = 0; n < 3; n++) begin
            randomize_resp(1, 300);
            do_scan(0, t);
            model_timeline(t);
            checks++; if (start_q.size() != N_CH) begin errors++; $display("FAIL rand%0d_start_count: got %0d expected %0d", n, start_q.size(), N_CH); end
            for (int k = 0; k < N_CH; k++) begin
                checks++; if (qget(start_q, k) != exp_start[k]) begin errors++; $display("FAIL rand%0d_start_cycle[%0d]: got %0d expected %0d", n, k, qget(start_q, k), exp_start[k]); end
            end
            checks++; if (ch_data !== exp_frame()) begin errors++; $display("FAIL rand%0d_ch_data: got %h expected %h", n, ch_data, exp_frame()); end
            checks++; if (fv_q.size() != 1 || qget(fv_q, 0) != exp_fv) begin errors++; $display("FAIL rand%0d_frame_valid: got %0d pulses at %0d expected 1 at %0d", n, fv_q.size(), qget(fv_q, 0), exp_fv); end
        end
    endtask

    task automatic test_held_done();
        int t;
        hold_mode = 1'b1;
        randomize_resp(2, 200);
        do_scan(0, t);
        model_timeline(t);
        checks++; if (start_q.size() != N_CH) begin errors++; $display("FAIL held_start_count: got %0d expected %0d", start_q.size(), N_CH); end
        for (int k = 0; k < N_CH; k++) begin
            checks++; if (qget(start_q, k) != exp_start[k]) begin errors++; $display("FAIL held_start_cycle[%0d]: got %0d expected %0d", k, qget(start_q, k), exp_start[k]); end
        end
        checks++; if (ch_data !== exp_frame()) begin errors++; $display("FAIL held_ch_data: got %h expected %h", ch_data, exp_frame()); end
        checks++; if (fv_q.size() != 1) begin errors++; $display("FAIL held_frame_count: got %0d expected 1", fv_q.size()); end
        hold_mode = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_overrun();
        int t;
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_before: got %b expected 0", overrun); end
        randomize_resp(270, 270);
        do_scan(100, t);
        model_timeline(t);
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_flag: got %b expected 1", overrun); end
        checks++; if (start_q.size() != N_CH) begin errors++; $display("FAIL overrun_start_count: got %0d expected %0d", start_q.size(), N_CH); end
        checks++; if (qget(start_q, N_CH - 1) != exp_start[N_CH - 1]) begin errors++; $display("FAIL overrun_last_start: got %0d expected %0d", qget(start_q, N_CH - 1), exp_start[N_CH - 1]); end
        checks++; if (ch_data !== exp_frame() || fv_q.size() != 1) begin errors++; $display("FAIL overrun_frame: got %h (%0d pulses) expected %h (1 pulse)", ch_data, fv_q.size(), exp_frame()); end
        last_frame = exp_frame();
    endtask

    task automatic test_timeout();
        int t;
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL timeout_before: got %b expected 0", timeout_err); end
        randomize_resp(50, 50);
        skip_ch = 2;
        do_scan(0, t);
        model_timeline(t);
        checks++; if (qget(to_q, 0) != exp_start[2] + TIMEOUT_CYC) begin errors++; $display("FAIL timeout_cycle: got %0d expected %0d", qget(to_q, 0), exp_start[2] + TIMEOUT_CYC); end
        checks++; if (qget(bfall_q, 0) != exp_start[2] + TIMEOUT_CYC) begin errors++; $display("FAIL timeout_busy_fall: got %0d expected %0d", qget(bfall_q, 0), exp_start[2] + TIMEOUT_CYC); end
        checks++; if (start_q.size() != 3 || fv_q.size() != 0) begin errors++; $display("FAIL timeout_activity: got %0d starts %0d frames expected 3 starts 0 frames", start_q.size(), fv_q.size()); end
        checks++; if (ch_data !== last_frame) begin errors++; $display("FAIL timeout_ch_data_kept: got %h expected %h", ch_data, last_frame); end
        skip_ch = -1;
        randomize_resp(1, 300);
        do_scan(0, t);
        model_timeline(t);
        checks++; if (ch_data !== exp_frame() || qget(fv_q, 0) != exp_fv) begin errors++; $display("FAIL timeout_recover: got %h at %0d expected %h at %0d", ch_data, qget(fv_q, 0), exp_frame(), exp_fv); end
        checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL timeout_sticky: got %b expected 1", timeout_err); end
    endtask

    task automatic test_async_reset();
        randomize_resp(270, 270);
        clear_events();
        trig = 1'b1;
        @(negedge clk);
        trig = 1'b0;
        for (int i = 0; i < 2000 && start_q.size() < 2; i++) @(negedge clk);
        checks++; if (start_q.size() < 2) begin errors++; $display("FAIL areset_reach_ch1: got %0d starts expected 2", start_q.size()); end
        repeat (20) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({adc_start, mux_sel, frame_valid, busy, overrun, timeout_err} !== 8'h00) begin
            errors++; $display("FAIL areset_outputs: got start/sel/fv/busy/ovr/to=%b expected all 0", {adc_start, mux_sel, frame_valid, busy, overrun, timeout_err});
        end
        checks++; if (ch_data !== '0) begin errors++; $display("FAIL areset_ch_data: got %h expected 0", ch_data); end
        @(negedge clk);
        rst_n = 1'b1;
        clear_events();
        repeat (2000) @(negedge clk);
        checks++; if (fv_q.size() != 0 || start_q.size() != 0 || busy !== 1'b0) begin
            errors++; $display("FAIL areset_quiet: got %0d frames %0d starts busy=%b expected none", fv_q.size(), start_q.size(), busy);
        end
    endtask

`ifdef ADC_OFFSET_CAL_EN
    task automatic test_offset_cal();
        int t;
        for (int k = 0; k < N_CH; k++) begin
            resp_data[k] = 16'h0800;
            resp_delay[k] = 40;
        end
        do_scan(0, t);
        checks++; if (fv_q.size() != 0 || bfall_q.size() != 1) begin errors++; $display("FAIL cal_frame1: got %0d frames %0d busy falls expected 0 and 1", fv_q.size(), bfall_q.size()); end
        for (int k = 0; k < N_CH; k++) resp_data[k] = (k % 2 == 0) ? 16'h0810 : 16'h07F0;
        do_scan(0, t);
        checks++; if (fv_q.size() != 1) begin errors++; $display("FAIL cal_frame2_valid: got %0d expected 1", fv_q.size()); end
        for (int k = 0; k < N_CH; k++) begin
            checks++; if (ch_data[16*k +: 16] !== ((k % 2 == 0) ? 16'h0010 : 16'hFFF0)) begin
                errors++; $display("FAIL cal_ch_data[%0d]: got %h expected %h", k, ch_data[16*k +: 16], (k % 2 == 0) ? 16'h0010 : 16'hFFF0);
            end
        end
    endtask
`endif

    initial begin
        for (int k = 0; k < N_CH; k++) begin
            resp_data[k] = '0;
            resp_delay[k] = 10;
        end
        @(negedge clk);
        test_reset();
`ifdef ADC_OFFSET_CAL_EN
        test_offset_cal();
`else
        test_basic_scan();
        test_random_scans();
        test_held_done();
        test_overrun();
        test_timeout();
        test_async_reset();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
